// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache control and RAM port bundle for mem_arbiter
interface mem_arbiter_if;
  // icache side
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // dcache side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  // performance counters
  logic [31:0] dcount;
  logic [31:0] icount;

  // arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
           dcount, icount
  );

  // cache pair plus RAM model view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
           dcount, icount
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter onto a single RAM port
module mem_arbiter (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave ccif
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_t;

  state_t      state;
  last_t       last;
  logic [31:0] dcount_q;
  logic [31:0] icount_q;
  logic        dreq;
  logic        ireq;
  logic        ram_done;

  assign dreq     = ccif.dREN | ccif.dWEN;
  assign ireq     = ccif.iREN;
  assign ram_done = (ccif.ramstate == RAM_ACCESS);

  // Grant FSM: a grant is held until its owner drops every request, so bursts are never split.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      last  <= LAST_I;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && ireq) begin
            state <= (last == LAST_I) ? DGRANT : IGRANT;
          end else if (dreq) begin
            state <= DGRANT;
          end else if (ireq) begin
            state <= IGRANT;
          end
        end
        DGRANT: begin
          if (!dreq) begin
            if (ireq) begin
              state <= IGRANT;
              last  <= LAST_D;
            end else begin
              state <= IDLE;
            end
          end
        end
        IGRANT: begin
          if (!ireq) begin
            if (dreq) begin
              state <= DGRANT;
              last  <= LAST_I;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completed-word counters; a word only counts while its owner still requests it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dcount_q <= '0;
      icount_q <= '0;
    end else begin
      if (state == DGRANT && ram_done && dreq) begin
        dcount_q <= dcount_q + 32'd1;
      end
      if (state == IGRANT && ram_done && ireq) begin
        icount_q <= icount_q + 32'd1;
      end
    end
  end

  // RAM port mux and per-side responses; strobes follow the live request so a release drops them at once.
  always_comb begin
    ccif.ramREN   = 1'b0;
    ccif.ramWEN   = 1'b0;
    ccif.ramaddr  = '0;
    ccif.ramstore = '0;
    ccif.dwait    = 1'b1;
    ccif.dload    = '0;
    ccif.iwait    = 1'b1;
    ccif.iload    = '0;
    case (state)
      DGRANT: begin
        ccif.ramWEN   = ccif.dWEN;
        ccif.ramREN   = ccif.dREN & ~ccif.dWEN;
        ccif.ramaddr  = ccif.daddr;
        ccif.ramstore = ccif.dstore;
        ccif.dload    = ccif.ramload;
        ccif.dwait    = ~ram_done;
      end
      IGRANT: begin
        ccif.ramREN   = ccif.iREN;
        ccif.ramaddr  = ccif.iaddr;
        ccif.iload    = ccif.ramload;
        ccif.iwait    = ~ram_done;
      end
      default: begin
      end
    endcase
  end

  assign ccif.dcount = dcount_q;
  assign ccif.icount = icount_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency/error RAM model
module tb_mem_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .ccif (bus)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit is_d;
    int cyc;
  } done_t;

  exp_t  dq[$];
  exp_t  iq[$];
  done_t done_log[$];
  exp_t  dmon;
  exp_t  imon;

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int exp_dcount  = 0;
  int exp_icount  = 0;

  logic [31:0] ref_mem [0:1023];
  logic [31:0] ram_mem [0:1023];

  // RAM model knobs and state
  int ram_lat      = 1;
  int ram_cnt      = 0;
  int err_budget   = 0;
  int err_used     = 0;
  int rnd_err_left = 0;
  bit rnd_err_en   = 1'b0;
  logic strobe;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input int idx);
    return (32'(idx) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  // RAM: N busy cycles after the strobe appears, then one ACCESS cycle; ERROR cycles stall it.
  assign strobe       = bus.ramREN | bus.ramWEN;
  assign bus.ramstate = !strobe ? FREE :
                        ((err_used < err_budget) || (rnd_err_left > 0)) ? ERROR :
                        (ram_cnt >= ram_lat) ? ACCESS : BUSY;
  assign bus.ramload  = (bus.ramstate == ACCESS && bus.ramREN) ? ram_mem[bus.ramaddr[11:2]] : 32'hBAD0BAD0;

  always @(posedge CLK) begin
    if (!strobe) begin
      ram_cnt <= 0;
    end else if (bus.ramstate == ACCESS) begin
      if (bus.ramWEN) ram_mem[bus.ramaddr[11:2]] <= bus.ramstore;
      ram_cnt <= 0;
    end else if (bus.ramstate == ERROR) begin
      if (err_used < err_budget) err_used <= err_used + 1;
      else rnd_err_left <= rnd_err_left - 1;
    end else begin
      ram_cnt <= ram_cnt + 1;
      if (rnd_err_en && ram_cnt == 0 && $urandom_range(0, 5) == 0) rnd_err_left <= $urandom_range(1, 3);
    end
  end

  // Monitor: every completed word is popped from its side's queue and compared.
  always @(negedge CLK) begin
    if (nRST) begin
      if (!bus.dwait && !bus.iwait) check("both_sides_complete", 32'd1, 32'd0);
      if (!bus.dwait) begin
        check("d_completion_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) begin
          dmon = dq.pop_front();
          check("d_ramaddr", bus.ramaddr, dmon.addr);
          check("d_ramWEN", 32'(bus.ramWEN), 32'(dmon.wr));
          check("d_ramREN", 32'(bus.ramREN), 32'(!dmon.wr));
          if (dmon.wr) check("d_ramstore", bus.ramstore, dmon.data);
          else         check("d_dload", bus.dload, dmon.data);
          done_log.push_back('{1'b1, cyc});
        end
      end
      if (!bus.iwait) begin
        check("i_completion_expected", 32'(iq.size() != 0), 32'd1);
        if (iq.size() != 0) begin
          imon = iq.pop_front();
          check("i_ramaddr", bus.ramaddr, imon.addr);
          check("i_ramREN", 32'(bus.ramREN), 32'd1);
          check("i_ramWEN", 32'(bus.ramWEN), 32'd0);
          check("i_iload", bus.iload, imon.data);
          done_log.push_back('{1'b0, cyc});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // dcache burst of n consecutive words; expectations are queued before the request goes out.
  task automatic d_burst(input logic [31:0] a0, input int n, input bit wr, input bit ren,
                         input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] a;
    logic [31:0] v;
    bit          seen;
    for (int k = 0; k < n; k++) begin
      a = a0 + 32'(4 * k);
      v = (k == 0) ? d0 : d1;
      if (wr) begin
        dq.push_back('{1'b1, a, v});
        ref_mem[a[11:2]] = v;
      end else begin
        dq.push_back('{1'b0, a, ref_mem[a[11:2]]});
      end
      exp_dcount++;
      bus.daddr  = a;
      bus.dstore = v;
      bus.dWEN   = wr;
      bus.dREN   = ren | ~wr;
      seen = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
        @(negedge CLK);
        seen = !bus.dwait;
      end
      if (!seen) check("d_word_timeout", 32'd0, 32'd1);
      step(1);
    end
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask

  task automatic i_read(input logic [31:0] a);
    bit seen;
    iq.push_back('{1'b0, a, ref_mem[a[11:2]]});
    exp_icount++;
    bus.iaddr = a;
    bus.iREN  = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge CLK);
      seen = !bus.iwait;
    end
    if (!seen) check("i_word_timeout", 32'd0, 32'd1);
    step(1);
    bus.iREN = 1'b0;
  endtask

  task automatic rnd_d_proc(input int words);
    int n;
    bit wr;
    for (int k = 0; k < words; k++) begin
      step($urandom_range(1, 3));
      n  = $urandom_range(1, 2);
      wr = 1'($urandom_range(0, 1));
      d_burst(32'($urandom_range(512, 1022)) << 2, n, wr, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
  endtask

  task automatic rnd_i_proc(input int words);
    for (int k = 0; k < words; k++) begin
      step($urandom_range(1, 3));
      i_read(32'($urandom_range(256, 511)) << 2);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit seen;
    for (int k = 0; k < 1024; k++) begin
      ref_mem[k] = init_val(k);
      ram_mem[k] = init_val(k);
    end
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    ram_mem[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    ram_lat = 2;

    // Reset held with the icache requesting
    step(3);
    check("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("rst_iwait", 32'(bus.iwait), 32'd1);
    check("rst_dwait", 32'(bus.dwait), 32'd1);
    check("rst_iload", bus.iload, 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_icount", bus.icount, 32'd0);
    check("rst_dcount", bus.dcount, 32'd0);

    // Release and single icache read with RAM latency 2
    iq.push_back('{1'b0, 32'h40, 32'hDEADBEEF});
    exp_icount = 1;
    nRST = 1'b1;
    r = cyc;
    #2;
    check("rel_ramREN_before_edge", 32'(bus.ramREN), 32'd0);
    @(posedge CLK); #1;
    check("rel_ramREN_after_edge", 32'(bus.ramREN), 32'd1);
    check("rel_ramaddr", bus.ramaddr, 32'h40);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge CLK);
      seen = !bus.iwait;
    end
    check("single_completes", 32'(seen), 32'd1);
    check("single_latency_N_plus_1", 32'(cyc - r), 32'd3);
    step(1);
    bus.iREN = 1'b0;
    @(negedge CLK);
    check("single_one_cycle_wait_low", 32'(bus.iwait), 32'd1);
    check("single_icount", bus.icount, 32'(exp_icount));

    // First contention after reset goes to D, then I with no idle bubble
    step(2);
    ram_lat = 1;
    done_log.delete();
    fork
      d_burst(32'h800, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      i_read(32'h400);
    join
    check("cont1_count", 32'(done_log.size()), 32'd2);
    if (done_log.size() == 2) begin
      check("cont1_first_is_d", 32'(done_log[0].is_d), 32'd1);
      check("cont1_handoff_gap", 32'(done_log[1].cyc - done_log[0].cyc), 32'd3);
    end

    // Next contention goes to I
    step(2);
    done_log.delete();
    fork
      d_burst(32'h810, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      i_read(32'h410);
    join
    check("cont2_count", 32'(done_log.size()), 32'd2);
    if (done_log.size() == 2) check("cont2_first_is_i", 32'(done_log[0].is_d), 32'd0);

    // Two-word writeback holds the grant against a waiting icache
    step(2);
    done_log.delete();
    fork
      d_burst(32'h100, 2, 1'b1, 1'b0, 32'h11, 32'h22);
      begin
        step(1);
        i_read(32'h200);
      end
    join
    check("wb_count", 32'(done_log.size()), 32'd3);
    if (done_log.size() == 3) begin
      check("wb_word0_d", 32'(done_log[0].is_d), 32'd1);
      check("wb_word1_d", 32'(done_log[1].is_d), 32'd1);
      check("wb_then_i", 32'(done_log[2].is_d), 32'd0);
    end
    check("wb_mem_0x100", ram_mem[32'h100 >> 2], 32'h11);
    check("wb_mem_0x104", ram_mem[32'h104 >> 2], 32'h22);
    check("wb_dcount", bus.dcount, 32'(exp_dcount));

    // ERROR for three cycles, then ACCESS
    step(2);
    ram_lat = 0;
    err_budget = err_used + 3;
    fork
      d_burst(32'h900, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      begin
        @(posedge CLK);
        for (int k = 0; k < 3; k++) begin
          @(negedge CLK);
          check("err_dwait_high", 32'(bus.dwait), 32'd1);
        end
        @(negedge CLK);
        check("err_then_access", 32'(bus.dwait), 32'd0);
      end
    join
    @(negedge CLK);
    check("err_dcount_once", bus.dcount, 32'(exp_dcount));

    // Request dropped before ACCESS: release without a count
    step(2);
    ram_lat = 5;
    bus.daddr = 32'h980;
    bus.dREN  = 1'b1;
    step(3);
    bus.dREN = 1'b0;
    #1;
    check("drop_ramREN_immediate", 32'(bus.ramREN), 32'd0);
    step(3);
    check("drop_no_count", bus.dcount, 32'(exp_dcount));

    // Write priority, then async reset in the middle of the burst
    step(2);
    ram_lat = 1;
    dq.push_back('{1'b1, 32'hA00, 32'h33});
    ref_mem[32'hA00 >> 2] = 32'h33;
    exp_dcount++;
    bus.daddr = 32'hA00; bus.dstore = 32'h33; bus.dREN = 1'b1; bus.dWEN = 1'b1;
    step(1);
    check("wp_ramWEN", 32'(bus.ramWEN), 32'd1);
    check("wp_ramREN", 32'(bus.ramREN), 32'd0);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge CLK);
      seen = !bus.dwait;
    end
    check("wp_word0_completes", 32'(seen), 32'd1);
    step(1);
    bus.daddr = 32'hA04; bus.dstore = 32'h44;
    #1;
    check("wp_word1_ramWEN", 32'(bus.ramWEN), 32'd1);
    check("wp_dcount_before_rst", bus.dcount, 32'(exp_dcount));
    #1;
    nRST = 1'b0;
    #1;
    check("rst_mid_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("rst_mid_dcount", bus.dcount, 32'd0);
    check("rst_mid_dwait", 32'(bus.dwait), 32'd1);
    dq.delete(); iq.delete();
    exp_dcount = 0; exp_icount = 0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0;
    step(2);
    nRST = 1'b1;

    // Randomized concurrent traffic with random RAM latency and error bursts
    rnd_err_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      ram_lat = $urandom_range(0, 3);
      fork
        rnd_d_proc(10);
        rnd_i_proc(12);
      join
      step(3);
      check("rnd_dcount", bus.dcount, 32'(exp_dcount));
      check("rnd_icount", bus.icount, 32'(exp_icount));
    end

    step(5);
    check("dq_drained", 32'(dq.size()), 32'd0);
    check("iq_drained", 32'(iq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
